// File: rtl/imm_field_encoder.sv
// rtl/imm_field_encoder.sv - packs an immediate value into an instruction's immediate fields (2-stage valid/ready).
// Optional error counter enabled by defining IMM_ENC_ERRCNT_EN.
`ifndef IMM_TYPE1
`define IMM_TYPE1 3'd1
`define IMM_TYPE2 3'd2
`define IMM_TYPE3 3'd3
`define IMM_TYPE4 3'd4
`define IMM_TYPE5 3'd5
`define IMM_TYPE6 3'd6
`endif

module imm_field_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [31:0]          in_imm,
  input  logic [3:0]           in_imm_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic                 out_err
`ifdef IMM_ENC_ERRCNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 err_clr
`endif
);

  logic        r_s1_valid;
  logic [31:0] r_s1_inst;
  logic [31:0] r_s1_imm;
  logic [3:0]  r_s1_sel;
  logic        r_s1_err;
  logic        r_s2_valid;
  logic [31:0] r_out_inst;
  logic        r_out_err;

  logic        w_s2_adv;
  logic        w_range_err;
  logic [31:0] w_packed;
  logic        w_uns;

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_adv;
  assign out_valid = r_s2_valid;
  assign out_inst  = r_out_inst;
  assign out_err   = r_out_err;
  assign w_uns     = in_imm_sel[3];

  // Range check on the incoming value; undefined format codes always flag.
  always_comb begin
    w_range_err = 1'b1;
    case (in_imm_sel[2:0])
      `IMM_TYPE1: w_range_err = |in_imm[11:0];
      `IMM_TYPE2: w_range_err = in_imm[0] |
                                (w_uns ? |in_imm[31:21] : (in_imm[31:21] != {11{in_imm[20]}}));
      `IMM_TYPE3,
      `IMM_TYPE5: w_range_err = w_uns ? |in_imm[31:12] : (in_imm[31:12] != {20{in_imm[11]}});
      `IMM_TYPE4: w_range_err = in_imm[0] |
                                (w_uns ? |in_imm[31:13] : (in_imm[31:13] != {19{in_imm[12]}}));
      `IMM_TYPE6: w_range_err = |in_imm[31:5];
      default:    w_range_err = 1'b1;
    endcase
  end

  always_comb begin
    w_packed = r_s1_inst;
    case (r_s1_sel[2:0])
      `IMM_TYPE1: w_packed[31:12] = r_s1_imm[31:12];
      `IMM_TYPE2: begin
        if (r_s1_sel[3]) begin
          w_packed[31:12] = r_s1_imm[20:1];
        end else begin
          w_packed[31]    = r_s1_imm[20];
          w_packed[30:21] = r_s1_imm[10:1];
          w_packed[20]    = r_s1_imm[11];
          w_packed[19:12] = r_s1_imm[19:12];
        end
      end
      `IMM_TYPE3: w_packed[31:20] = r_s1_imm[11:0];
      `IMM_TYPE4: begin
        w_packed[31]    = r_s1_imm[12];
        w_packed[7]     = r_s1_imm[11];
        w_packed[30:25] = r_s1_imm[10:5];
        w_packed[11:8]  = r_s1_imm[4:1];
      end
      `IMM_TYPE5: begin
        w_packed[31:25] = r_s1_imm[11:5];
        w_packed[11:7]  = r_s1_imm[4:0];
      end
      `IMM_TYPE6: w_packed[29:25] = r_s1_imm[4:0];
      default:    w_packed = r_s1_inst;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_s1_valid <= 1'b0;
      r_s1_inst  <= '0;
      r_s1_imm   <= '0;
      r_s1_sel   <= '0;
      r_s1_err   <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_inst <= in_inst;
        r_s1_imm  <= in_imm;
        r_s1_sel  <= in_imm_sel;
        r_s1_err  <= w_range_err;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_s2_valid <= 1'b0;
      r_out_inst <= '0;
      r_out_err  <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_inst <= w_packed;
        r_out_err  <= r_s1_err;
      end
    end
  end

`ifdef IMM_ENC_ERRCNT_EN
  logic [ERR_CNT_W-1:0] r_err_count;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_err_count <= '0;
    end else if (err_clr) begin
      r_err_count <= '0;
    end else if (r_s2_valid && out_ready && r_out_err && !(&r_err_count)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign err_count = r_err_count;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = |ERR_CNT_W;
`endif

endmodule
